cdc_afifo_wpacker: RTL and testbench
====================================

# cdc_afifo_wpacker

Write-side beat packer placed directly upstream of the asynchronous CDC FIFO, in the write clock domain. It accepts narrow beats over a valid/ready handshake and packs `ratio` beats, or fewer when `i_last` is seen, into one wide FIFO word tagged with a beat count. It pushes words into the FIFO write port, obeys the FIFO full flag, and back-pressures the producer without losing or duplicating beats.

## Interface
Parameters:
- `ibits`, 8: input beat width.
- `ratio`, 4: beats per packed word; power of two, ≥2.
- `cbits`, $clog2(ratio): count field width.
- `tmo`, 16: idle-flush timeout in cycles. Used only with the configuration macro.
- Derived: FIFO `dbits` = `cbits + ratio*ibits`.

Ports:
- `i_nrst` in 1: reset; asynchronous, active-low.
- `i_wclk` in 1: clock. All logic is on the rising edge.
- `i_valid` in 1: producer beat valid.
- `i_data` in `ibits`: producer beat data.
- `i_last` in 1: beat closes the current word.
- `o_ready` out 1: packer can accept a beat this cycle.
- `o_wr` out 1: FIFO write strobe.
- `o_wdata` out `cbits+ratio*ibits`: `{cnt, lanes}`. `cnt` = valid beats − 1. Lane 0 is the LSBs and holds the first beat.
- `i_wfull` in 1: FIFO full flag, registered on the FIFO side.
- `o_busy` out 1: a partial or complete word is held.

## Operation
State is two registers:
- **Staging:** lane array, lane index `r_idx[cbits]`, `r_pend` (staging holds a completed word that could not move).
- **Output:** `r_owdata`, `r_ovalid`.

Handshake and lane fill:
- A beat is accepted when `i_valid && o_ready`.
- An accepted beat is written to lane `r_idx`.
- Unused lanes of a short word are zero.

Word completion:
- A word completes on an accepted beat when `r_idx == ratio-1` or `i_last == 1`.
- If the output register is empty, or is draining this cycle, the completed word loads into it with `cnt = r_idx`. `r_idx` returns to 0 and the lanes clear.
- Otherwise `r_pend` is set. The word moves to the output register on the first cycle the output register drains, and `r_pend` then clears.

Output and back-pressure:
- `o_ready = ~r_pend`.
- `o_wr = r_ovalid & ~i_wfull`. This is combinational from `i_wfull`.
- The output register drains whenever `o_wr == 1`, because the FIFO accepts every `i_wr` issued while not full.
- `o_busy = r_ovalid | r_pend | (r_idx != 0)`.

Boundary conditions:
- **Simultaneous drain and complete:** the new word loads in the same edge. No bubble.
- **`i_last` on the first beat:** the word is emitted with `cnt = 0`.
- **`i_wfull` asserted:** `o_wr` is 0 and data is held. Staging continues to fill until it completes a word, then `o_ready` drops.
- **`r_idx` wrap-around:** `ratio-1` returns to 0 only on completion. No overflow path exists.
- **`i_valid` while `o_ready` is 0:** ignored. The producer must hold the beat.
- **Reset mid-word:** asynchronous clear of everything.
  - Partial and pending words are discarded.
  - `r_idx`, `r_pend` and `r_ovalid` go to 0, and `r_owdata` to 0.
  - The FIFO resets on the same `i_nrst`.

## Timing
Reset values:
- `o_ready` = 1.
- `o_wr` = 0.
- `o_wdata` = 0.
- `o_busy` = 0.

Latency and throughput:
- A beat completing a word at edge N gives `o_wr = 1` in cycle N+1, if the FIFO is not full.
- Sustained throughput is one beat per cycle and one FIFO word per `ratio` cycles, with no stalls while the FIFO is not full.
- Worst-case storage before back-pressure is two words: output plus staging.

## Configuration
Macro: `CDC_AFIFO_WPACK_TIMEOUT_EN`.

Defined:
- An idle counter (width $clog2(tmo+1)) resets on every accepted beat.
- It increments while `r_idx != 0`, `!r_pend`, and no beat is accepted.
- On reaching `tmo`, the partial word completes exactly as if `i_last` had arrived, with `cnt = r_idx-1`. The counter then clears.
- If the output register is busy, the completed word goes to `r_pend`.

Undefined:
- No counter exists.
- A partial word is held indefinitely until more beats or `i_last` arrive.

## Test plan
- **Reset:** release reset, idle 5 cycles → `o_ready=1`, `o_wr=0`, `o_wdata=0`, `o_busy=0`.
- **Full word:** beats 0x11,0x22,0x33,0x44 on consecutive cycles with `i_wfull=0` → a single `o_wr` one cycle after 0x44, `o_wdata={2'd3, 32'h44332211}`.
- **Short word:** beats 0xA1,0xA2 with `i_last` on 0xA2 → `o_wdata={2'd1, 32'h0000A2A1}`.
- **FIFO full:**
  - Stimulus: hold `i_wfull=1`, stream 12 beats 0x01..0x0C.
  - Back-pressure: `o_ready` drops after 8 accepted beats; `o_wr` stays 0.
  - Release `i_wfull`: words 0x04030201 then 0x08070605 are written on consecutive cycles, and beats 0x09..0x0C are then accepted.
  - Result: exactly 3 writes total, in order.
- **Reset mid-word:** 2 beats, then pulse `i_nrst` low → no `o_wr`; the next 4 beats produce a single word holding only the new data.
- **Timeout (macro on, `tmo=16`):** beat 0x5A then idle → `o_wr` after 16 idle cycles with `o_wdata={2'd0, 32'h0000005A}`. With the macro off, no write occurs within 100 cycles.

Source files
------------

// File: rtl/cdc_afifo_wpacker.sv
// cdc_afifo_wpacker: write-side beat packer feeding an asynchronous CDC FIFO.
// Packs up to `ratio` narrow beats into one FIFO word {cnt, lanes}. cnt is the
// number of valid beats minus one, and lane 0 holds the first beat. Storage is
// one output word plus one staging word, and the producer is back-pressured
// only when both are occupied.
// Optional feature: define CDC_AFIFO_WPACK_TIMEOUT_EN to flush a partial word
// after `tmo` idle cycles.
module cdc_afifo_wpacker #(
  parameter int unsigned ibits = 8,
  parameter int unsigned ratio = 4,
  parameter int unsigned cbits = $clog2(ratio),
  parameter int unsigned tmo   = 16
) (
  input  logic                         i_nrst,
  input  logic                         i_wclk,
  input  logic                         i_valid,
  input  logic [ibits-1:0]             i_data,
  input  logic                         i_last,
  output logic                         o_ready,
  output logic                         o_wr,
  output logic [cbits+ratio*ibits-1:0] o_wdata,
  input  logic                         i_wfull,
  output logic                         o_busy
);

  localparam int unsigned LBITS = ratio * ibits;
  localparam int unsigned DBITS = cbits + LBITS;
  localparam logic [cbits-1:0] IDX_LAST = cbits'(ratio - 1);

  // Elaboration-time parameter sanity checks
  if ((ratio < 2) || ((ratio & (ratio - 1)) != 0)) begin : g_bad_ratio
    $error("cdc_afifo_wpacker: ratio must be a power of two >= 2");
  end
  if (tmo == 0) begin : g_bad_tmo
    $error("cdc_afifo_wpacker: tmo must be nonzero");
  end

  // Staging word
  logic [LBITS-1:0] r_lanes;
  logic [cbits-1:0] r_idx;
  logic             r_pend;
  logic [cbits-1:0] r_pcnt;
  // Output word
  logic [DBITS-1:0] r_owdata;
  logic             r_ovalid;

  // Next-state values
  logic [LBITS-1:0] w_lanes_nx;
  logic [cbits-1:0] w_idx_nx;
  logic             w_pend_nx;
  logic [cbits-1:0] w_pcnt_nx;
  logic [DBITS-1:0] w_owdata_nx;
  logic             w_ovalid_nx;

  // Datapath helpers
  logic             w_acc;
  logic             w_drain;
  logic [LBITS-1:0] w_lanes_upd;
  logic             w_cmp_beat;
  logic             w_cmp_tmo;
  logic             w_cmp;
  logic [cbits-1:0] w_cnt;
  logic             w_oload;

  assign w_acc   = i_valid & ~r_pend;
  assign w_drain = r_ovalid & ~i_wfull;

  // Lane array with the accepted beat written at the current index
  always_comb begin
    w_lanes_upd = r_lanes;
    for (int unsigned l = 0; l < ratio; l++) begin
      if (w_acc && (r_idx == cbits'(l))) begin
        w_lanes_upd[l*ibits +: ibits] = i_data;
      end
    end
  end

  assign w_cmp_beat = w_acc & ((r_idx == IDX_LAST) | i_last);

`ifdef CDC_AFIFO_WPACK_TIMEOUT_EN
  localparam int unsigned TBITS = $clog2(tmo + 1);

  logic [TBITS-1:0] r_tmo;
  logic [TBITS-1:0] w_tmo_nx;
  logic             w_idle;

  // Idle means a partial word is held, nothing pending, and no beat arrives
  assign w_idle    = ~w_acc & ~r_pend & (r_idx != '0);
  assign w_cmp_tmo = w_idle & (r_tmo == TBITS'(tmo - 1));

  // Idle counter next value: cleared by any beat or by its own flush
  always_comb begin
    w_tmo_nx = r_tmo;
    if (w_acc || w_cmp_tmo) begin
      w_tmo_nx = '0;
    end else if (w_idle) begin
      w_tmo_nx = r_tmo + TBITS'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge i_wclk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= w_tmo_nx;
    end
  end
`else
  assign w_cmp_tmo = 1'b0;
`endif

  assign w_cmp = w_cmp_beat | w_cmp_tmo;
  // A beat completion counts the beat just taken; a flush counts lanes filled so far
  assign w_cnt = w_cmp_beat ? r_idx : (r_idx - cbits'(1));
  // The output slot can take a new word if it is empty or empties this cycle
  assign w_oload = ~r_ovalid | w_drain;

  // Next-state for staging and output words
  always_comb begin
    w_lanes_nx  = r_lanes;
    w_idx_nx    = r_idx;
    w_pend_nx   = r_pend;
    w_pcnt_nx   = r_pcnt;
    w_owdata_nx = r_owdata;
    w_ovalid_nx = r_ovalid;

    if (w_drain) begin
      w_ovalid_nx = 1'b0;
    end

    if (r_pend) begin
      // Completed word waiting in staging moves as soon as the output drains
      if (w_drain) begin
        w_owdata_nx = {r_pcnt, r_lanes};
        w_ovalid_nx = 1'b1;
        w_lanes_nx  = '0;
        w_pend_nx   = 1'b0;
      end
    end else if (w_cmp) begin
      w_idx_nx = '0;
      if (w_oload) begin
        w_owdata_nx = {w_cnt, w_lanes_upd};
        w_ovalid_nx = 1'b1;
        w_lanes_nx  = '0;
      end else begin
        w_pend_nx  = 1'b1;
        w_pcnt_nx  = w_cnt;
        w_lanes_nx = w_lanes_upd;
      end
    end else if (w_acc) begin
      w_lanes_nx = w_lanes_upd;
      w_idx_nx   = r_idx + cbits'(1);
    end
  end

  // State registers
  always_ff @(posedge i_wclk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_lanes  <= '0;
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_pcnt   <= '0;
      r_owdata <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_lanes  <= w_lanes_nx;
      r_idx    <= w_idx_nx;
      r_pend   <= w_pend_nx;
      r_pcnt   <= w_pcnt_nx;
      r_owdata <= w_owdata_nx;
      r_ovalid <= w_ovalid_nx;
    end
  end

  assign o_ready = ~r_pend;
  assign o_wr    = w_drain;
  assign o_wdata = r_owdata;
  assign o_busy  = r_ovalid | r_pend | (r_idx != '0);

endmodule

// File: tb/tb_cdc_afifo_wpacker.sv
// Testbench for cdc_afifo_wpacker (default parameters: 8-bit beats, ratio 4).
// A queue-level model tracks completed words and the current partial word and
// is compared against the DUT every cycle, alongside directed literal checks.
module tb_cdc_afifo_wpacker;

  localparam int TMO = 16;

  logic        clk;
  logic        i_nrst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_last;
  logic        o_ready;
  logic        o_wr;
  logic [33:0] o_wdata;
  logic        i_wfull;
  logic        o_busy;

  cdc_afifo_wpacker #(.ibits(8), .ratio(4), .tmo(TMO)) dut (
    .i_nrst  (i_nrst),
    .i_wclk  (clk),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_wr    (o_wr),
    .o_wdata (o_wdata),
    .i_wfull (i_wfull),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [33:0] wlog[$];
  int          wcyc[$];

  // Behavioural model: completed words in order, beats of the open word
  logic [33:0] m_held[$];
  logic [7:0]  m_part[$];
  int          m_idle = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [33:0] pack_part();
    logic [33:0] w;
    w = '0;
    foreach (m_part[i]) w[i*8 +: 8] = m_part[i];
    w[33:32] = 2'(m_part.size() - 1);
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model, then advance the model over the next edge
  always @(negedge clk) begin
    logic e_ready, e_wr, e_busy, acc, fire;
    if (o_wr === 1'b1) begin
      wlog.push_back(o_wdata);
      wcyc.push_back(cyc);
    end
    if (!i_nrst) begin
      m_held.delete();
      m_part.delete();
      m_idle = 0;
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_wr",    64'(o_wr),    64'd0);
      chk("rst_wdata", 64'(o_wdata), 64'd0);
      chk("rst_busy",  64'(o_busy),  64'd0);
    end else begin
      e_ready = (m_held.size() < 2);
      e_wr    = (m_held.size() > 0) && !i_wfull;
      e_busy  = (m_held.size() > 0) || (m_part.size() > 0);
      chk("m_ready", 64'(o_ready), 64'(e_ready));
      chk("m_wr",    64'(o_wr),    64'(e_wr));
      chk("m_busy",  64'(o_busy),  64'(e_busy));
      if (e_wr) chk("m_wdata", 64'(o_wdata), 64'(m_held[0]));
      acc  = i_valid && e_ready;
      fire = 1'b0;
      if (e_wr) void'(m_held.pop_front());
      if (acc) begin
        m_part.push_back(i_data);
        m_idle = 0;
        if (m_part.size() == 4 || i_last) fire = 1'b1;
      end else if (m_part.size() > 0 && e_ready) begin
        m_idle++;
`ifdef CDC_AFIFO_WPACK_TIMEOUT_EN
        if (m_idle == TMO) fire = 1'b1;
`endif
      end
      if (fire) begin
        m_held.push_back(pack_part());
        m_part.delete();
        m_idle = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [7:0] d, input logic l);
    logic ok;
    int   n;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = o_ready;
      tick();
      n++;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  initial begin
    logic ok;
    int   k;
    int   nacc;

    i_nrst  = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_wfull = 1'b0;
    repeat (3) tick();
    i_nrst = 1'b1;

    // Reset values after idle
    repeat (5) tick();
    @(negedge clk);
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_wr",    64'(o_wr),    64'd0);
    chk("reset_wdata", 64'(o_wdata), 64'd0);
    chk("reset_busy",  64'(o_busy),  64'd0);
    tick();

    // Full word, write one cycle after the last beat
    wlog.delete(); wcyc.delete();
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    @(negedge clk);
    chk("full_wr_latency", 64'(o_wr),    64'd1);
    chk("full_wdata",      64'(o_wdata), 64'h3_4433_2211);
    repeat (5) tick();
    chk("full_nwr", 64'(wlog.size()), 64'd1);

    // Short word closed by i_last
    wlog.delete(); wcyc.delete();
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b1);
    repeat (5) tick();
    chk("short_nwr", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("short_wdata", 64'(wlog[0]), 64'h1_0000_A2A1);

    // i_last on first beat
    wlog.delete(); wcyc.delete();
    send_beat(8'hC7, 1'b1);
    repeat (5) tick();
    chk("first_last_nwr", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("first_last_wdata", 64'(wlog[0]), 64'h0_0000_00C7);

    // FIFO full: two words stored, then back-pressure
    wlog.delete(); wcyc.delete();
    i_wfull = 1'b1;
    k = 1;
    nacc = 0;
    for (int c = 0; c < 20; c++) begin
      i_valid = 1'b1;
      i_data  = 8'(k);
      i_last  = 1'b0;
      @(negedge clk);
      ok = o_ready;
      tick();
      if (ok) begin
        k++;
        nacc++;
      end
    end
    chk("ffull_accepted", 64'(nacc), 64'd8);
    chk("ffull_nowr",     64'(wlog.size()), 64'd0);
    @(negedge clk);
    chk("ffull_ready", 64'(o_ready), 64'd0);
    chk("ffull_busy",  64'(o_busy),  64'd1);
    tick();
    i_wfull = 1'b0;
    for (int c = 0; c < 40 && k <= 12; c++) begin
      i_valid = 1'b1;
      i_data  = 8'(k);
      @(negedge clk);
      ok = o_ready;
      tick();
      if (ok) k++;
    end
    i_valid = 1'b0;
    chk("ffull_all_taken", 64'(k), 64'd13);
    repeat (8) tick();
    chk("ffull_nwr", 64'(wlog.size()), 64'd3);
    if (wlog.size() == 3) begin
      chk("ffull_w0", 64'(wlog[0]), 64'h3_0403_0201);
      chk("ffull_w1", 64'(wlog[1]), 64'h3_0807_0605);
      chk("ffull_w2", 64'(wlog[2]), 64'h3_0C0B_0A09);
      chk("ffull_back2back", 64'(wcyc[1] - wcyc[0]), 64'd1);
    end

    // Reset mid-word discards the partial word
    wlog.delete(); wcyc.delete();
    send_beat(8'h71, 1'b0);
    send_beat(8'h72, 1'b0);
    i_nrst = 1'b0;
    tick();
    i_nrst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    tick();
    send_beat(8'h81, 1'b0);
    send_beat(8'h82, 1'b0);
    send_beat(8'h83, 1'b0);
    send_beat(8'h84, 1'b0);
    repeat (5) tick();
    chk("midrst_nwr", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("midrst_wdata", 64'(wlog[0]), 64'h3_8483_8281);

    // Partial word left idle
    wlog.delete(); wcyc.delete();
    send_beat(8'h5A, 1'b0);
`ifdef CDC_AFIFO_WPACK_TIMEOUT_EN
    repeat (TMO - 1) tick();
    chk("tmo_early", 64'(wlog.size()), 64'd0);
    repeat (10) tick();
    chk("tmo_nwr", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) begin
      chk("tmo_wdata", 64'(wlog[0]), 64'h0_0000_005A);
      chk("tmo_cycle", 64'(wcyc[0] - cyc + 10), 64'(TMO + 1 - (TMO - 1)));
    end
`else
    repeat (100) tick();
    chk("notmo_nwr", 64'(wlog.size()), 64'd0);
    @(negedge clk);
    chk("notmo_busy", 64'(o_busy), 64'd1);
    tick();
`endif

    // Randomized traffic with random and bursty FIFO-full
    for (int c = 0; c < 3000; c++) begin
      if (!i_valid && $urandom_range(0, 3) != 0) begin
        i_valid = 1'b1;
        i_data  = 8'($urandom);
        i_last  = ($urandom_range(0, 4) == 0);
      end
      i_wfull = ((c % 200) >= 150) ? 1'b1 : ($urandom_range(0, 9) < 3);
      if ((c % 500) == 400) i_valid = 1'b0;
      @(negedge clk);
      ok = o_ready;
      tick();
      if (i_valid && ok) begin
        i_valid = 1'b0;
        i_last  = 1'b0;
      end
      if ((c % 500) == 400) repeat (30) tick();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_wfull = 1'b0;
    repeat (50) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
